// File: rtl/jamma_pkg.sv
// Shared types and idle constants for the JAMMA control-edge scanner.
package jamma_pkg;

    typedef enum logic [1:0] {
        S1_SETTLE = 2'd0,
        S1_SAMPLE = 2'd1,
        S2_SETTLE = 2'd2,
        S2_SAMPLE = 2'd3
    } scan_state_e;

    localparam logic [7:0] JOY_IDLE    = 8'hFF;
    localparam logic [1:0] COIN_IDLE   = 2'b11;
    localparam logic [3:0] DEB_CNT_MAX = 4'd15;

endpackage

// File: rtl/jamma_joy_scanner_bit_debouncer.sv
// Single-bit agreement-counter debouncer, updated only when sample_en is high.
module bit_debouncer
    import jamma_pkg::*;
#(
    parameter int DEBOUNCE_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_en,
    input  logic din,
    output logic dout
);

    localparam logic [3:0] LEN = 4'(DEBOUNCE_LEN);

    logic       last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    logic       out_q, out_d;

    // Next-state: count agreeing samples, adopt the sample once the count hits LEN
    always_comb begin
        last_d = last_q;
        cnt_d  = cnt_q;
        out_d  = out_q;
        if (sample_en) begin
            if (din == last_q) begin
                if (cnt_q != DEB_CNT_MAX) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end else begin
                cnt_d  = 4'd1;
                last_d = din;
            end
            if (cnt_d == LEN) begin
                out_d = din;
            end else begin
                out_d = out_q;
            end
        end else begin
            out_d = out_q;
        end
    end

    // Debounce state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
            cnt_q  <= 4'd0;
            out_q  <= 1'b1;
        end else begin
            last_q <= last_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
        end
    end

    assign dout = out_q;

endmodule

// File: rtl/jamma_joy_scanner.sv
// Time-multiplexed JAMMA bank scanner: drives JSELECT, settles, samples,
// debounces both player banks and coins, and merges the local DB9 joystick.
module jamma_joy_scanner
    import jamma_pkg::*;
#(
    parameter int SETTLE_CYCLES = 8,
    parameter int DEBOUNCE_LEN  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] jjoy,
    input  logic [1:0] jcoin,
    input  logic [5:0] local_joy,
    output logic       jselect,
    output logic [7:0] joystick1,
    output logic [7:0] joystick2,
    output logic [1:0] coin,
    output logic       scan_done
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    scan_state_e state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        jselect_q, jselect_d;
    logic        scan_done_q, scan_done_d;
    logic [5:0]  sync1_q, sync2_q;
    logic [7:0]  joystick1_q, joystick1_d;
    logic [7:0]  joystick2_q, joystick2_d;
    logic [1:0]  coin_q, coin_d;

    logic        p1_en_s, p2_en_s, coin_en_s;
    logic [7:0]  p1_deb_s, p2_deb_s;
    logic [1:0]  coin_deb_s;

    // Scan FSM next-state; jselect follows the state being entered so it is glitch-free
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S1_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S1_SAMPLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S1_SAMPLE: state_d = S2_SETTLE;
            S2_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S2_SAMPLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S2_SAMPLE: state_d = S1_SETTLE;
            default: begin
                state_d = S1_SETTLE;
                cnt_d   = 8'd0;
            end
        endcase
        jselect_d   = (state_d == S2_SETTLE) || (state_d == S2_SAMPLE);
        scan_done_d = (state_q == S2_SAMPLE);
        joystick1_d = {p1_deb_s[7:6], p1_deb_s[5:0] & sync2_q};
        joystick2_d = p2_deb_s;
        coin_d      = coin_deb_s;
    end

    assign p1_en_s   = (state_q == S1_SAMPLE);
    assign p2_en_s   = (state_q == S2_SAMPLE);
    assign coin_en_s = p1_en_s | p2_en_s;

    // FSM, synchronizer and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S1_SETTLE;
            cnt_q       <= 8'd0;
            jselect_q   <= 1'b0;
            scan_done_q <= 1'b0;
            sync1_q     <= 6'h3F;
            sync2_q     <= 6'h3F;
            joystick1_q <= JOY_IDLE;
            joystick2_q <= JOY_IDLE;
            coin_q      <= COIN_IDLE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            jselect_q   <= jselect_d;
            scan_done_q <= scan_done_d;
            sync1_q     <= local_joy;
            sync2_q     <= sync1_q;
            joystick1_q <= joystick1_d;
            joystick2_q <= joystick2_d;
            coin_q      <= coin_d;
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_bank
        bit_debouncer #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_p1 (
            .clk(clk), .reset(reset), .sample_en(p1_en_s), .din(jjoy[i]), .dout(p1_deb_s[i])
        );
        bit_debouncer #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_p2 (
            .clk(clk), .reset(reset), .sample_en(p2_en_s), .din(jjoy[i]), .dout(p2_deb_s[i])
        );
    end

    for (genvar i = 0; i < 2; i++) begin : g_coin
        bit_debouncer #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_coin (
            .clk(clk), .reset(reset), .sample_en(coin_en_s), .din(jcoin[i]), .dout(coin_deb_s[i])
        );
    end

    assign jselect   = jselect_q;
    assign scan_done = scan_done_q;
    assign joystick1 = joystick1_q;
    assign joystick2 = joystick2_q;
    assign coin      = coin_q;

endmodule
